// File: rtl/wb_sequencer.sv
// Write-back sequencer: accepts one request, waits for MDR / High-Low validity, then pulses the write.
// Optional build macro WB_R0_GUARD_EN suppresses the register-file write for destination r0.
module wb_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_src,
  input  logic [4:0] req_rd,
  input  logic       mem_done,
  input  logic       md_busy,
  output logic [3:0] mem_to_reg,
  output logic [4:0] write_reg,
  output logic       reg_write,
  output logic       wb_done,
  output logic       err_illegal,
  output logic       err_timeout,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_MD  = 2'd2,
    WRITE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             waiting;
  logic             cond;
  logic             tmo;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while IDLE, so at most one request is in flight.
  assign accept  = req_valid && (state == IDLE);
  assign waiting = (state == WAIT_MEM) || (state == WAIT_MD);
  assign cond    = (state == WAIT_MEM) ? mem_done : !md_busy;
  // A true condition in the cycle the count hits the limit still wins.
  assign tmo     = waiting && !cond && (cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (req_src)
            4'd3:                      state_nxt = WAIT_MEM;
            4'd1, 4'd2:                state_nxt = WAIT_MD;
            4'd0, 4'd4, 4'd5, 4'd6,
            4'd7, 4'd8:                state_nxt = WRITE;
            default:                   state_nxt = IDLE;
          endcase
        end
      end
      WAIT_MEM, WAIT_MD: begin
        if (cond) begin
          state_nxt = WRITE;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_to_reg  <= '0;
      write_reg   <= '0;
      cnt         <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= accept && (req_src > 4'd8);
      err_timeout <= tmo;
      if (accept) begin
        mem_to_reg <= req_src;
        write_reg  <= req_rd;
        cnt        <= '0;
      end else if (waiting && !cond && !tmo) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    wb_done   = (state == WRITE);
`ifdef WB_R0_GUARD_EN
    reg_write = (state == WRITE) && (write_reg != 5'd0);
`else
    reg_write = (state == WRITE);
`endif
    state_dbg = state;
  end

endmodule
